// File: rtl/pool_line_streamer.sv
// Streaming 2x2 stride-2 average-pooling front-end: raster pixels in, one pooled pixel per window out.
// Even-row column-pair sums are held in a half-width line buffer until the matching odd row arrives.
module pool_line_streamer #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              busy,
  output logic              finish
);

  localparam int HALF_W = IMG_W / 2;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [COL_W-1:0]  col_r;
  logic [ROW_W-1:0]  row_r;
  logic [DATA_W-1:0] pair_r;
  logic [DATA_W-1:0] lbuf_r [HALF_W];

  logic              accept_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] sum_s;

  assign in_ready = (state_r == RUN) && (!out_valid || out_ready);
  assign busy     = (state_r != IDLE);
  assign accept_s = in_valid && in_ready;
  assign idx_s    = IDX_W'(col_r >> 1);
  // Window sum wraps modulo 2^DATA_W to stay bit-exact with the combinational pooling unit.
  assign sum_s    = lbuf_r[idx_s] + pair_r + in_pixel;

  // Frame FSM, raster counters, pair register and single-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      col_r     <= {COL_W{1'b0}};
      row_r     <= {ROW_W{1'b0}};
      pair_r    <= {DATA_W{1'b0}};
      out_valid <= 1'b0;
      out_pixel <= {DATA_W{1'b0}};
      finish    <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
            col_r   <= {COL_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
          end
        end
        RUN: begin
          if (accept_s) begin
            if (col_r == COL_LAST) begin
              col_r <= {COL_W{1'b0}};
              if (row_r == ROW_LAST) begin
                row_r   <= {ROW_W{1'b0}};
                state_r <= DONE;
              end else begin
                row_r <= row_r + {{(ROW_W-1){1'b0}}, 1'b1};
              end
            end else begin
              col_r <= col_r + {{(COL_W-1){1'b0}}, 1'b1};
            end
          end
        end
        DONE: begin
          // finish is raised while still in DONE so a start is only honoured after the pulse.
          if (finish) begin
            state_r <= IDLE;
          end else if (!out_valid || out_ready) begin
            finish <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase

      if (accept_s && !col_r[0]) begin
        pair_r <= in_pixel;
      end

      if (accept_s && row_r[0] && col_r[0]) begin
        out_valid <= 1'b1;
        out_pixel <= {2'b00, sum_s[DATA_W-1:2]};
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Line buffer holds even-row column-pair sums; contents need no reset.
  always_ff @(posedge clk) begin
    if (accept_s && !row_r[0] && col_r[0]) begin
      lbuf_r[idx_s] <= pair_r + in_pixel;
    end
  end

endmodule
